id_operand_fetch: RTL

- Decode-side read initiator for the 2-read/1-write register file.
- Drives both read ports, forwards in-flight results from the EX and MEM stages, and detects load-use hazards, stalling on them.
- Registers the resolved operands into the ID/EX pipeline register.
- Sits between instruction decode and the EX stage; the register file itself already bypasses the WB write port.

---
 rtl/id_operand_fetch_pkg.sv | 23 ++
 rtl/id_operand_fetch_if.sv | 27 ++
 rtl/id_operand_fetch_fwd_mux.sv | 55 +++++
 rtl/id_operand_fetch.sv | 114 +++++++++++
 4 files changed

// File: rtl/id_operand_fetch_pkg.sv
// Shared widths and constants for the decode-side operand fetch slice.
// Optional build macro used by this slice: OPF_MEM_FWD_EN (MEM-stage forwarding path).
package id_operand_fetch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_W_DEF-1:0] NOP_REG   = '0;

    localparam logic RE_ON  = 1'b1;
    localparam logic RE_OFF = 1'b0;
    localparam logic WE_ON  = 1'b1;
    localparam logic WE_OFF = 1'b0;

    // Next-edge action of the ID/EX register.
    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2
    } idex_upd_e;

endpackage

// File: rtl/id_operand_fetch_if.sv
// Decode -> operand-fetch instruction handshake.
// An instruction transfers on a cycle where in_valid and in_ready are both high; in_ready may
// depend combinationally on the payload, and the master keeps the payload stable until it transfers.
interface id_operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs_i;
    logic [ADDR_W-1:0] rt_i;
    logic              use_rs_i;
    logic              use_rt_i;
    logic [DATA_W-1:0] imm_i;
    logic [ADDR_W-1:0] wd_i;
    logic              wreg_i;

    modport master (
        output in_valid, rs_i, rt_i, use_rs_i, use_rt_i, imm_i, wd_i, wreg_i,
        input  in_ready
    );

    modport slave (
        input  in_valid, rs_i, rt_i, use_rs_i, use_rt_i, imm_i, wd_i, wreg_i,
        output in_ready
    );
endinterface

// File: rtl/id_operand_fetch_fwd_mux.sv
// Single-port operand resolver: r0 / EX / MEM / register-file priority, plus a flag when the
// needed value is still in flight. MEM forwarding exists only with OPF_MEM_FWD_EN.
module opf_fwd_mux
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wreg,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] data,
    output logic              pending
);
    logic is_zero;
    logic ex_hit;
    logic mem_hit;

    assign is_zero = (addr == ADDR_W'(NOP_REG));
    assign ex_hit  = ex_wreg && (ex_wd == addr);
    assign mem_hit = mem_wreg && (mem_wd == addr);

`ifndef OPF_MEM_FWD_EN
    logic unused_mem_wdata;
    assign unused_mem_wdata = ^mem_wdata;
`endif

    // r0 is checked first so writes to it are never forwarded and never stall.
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        if (is_zero) begin
            data = DATA_W'(ZERO_WORD);
        end else if (ex_hit) begin
            if (ex_is_load) pending = 1'b1;
            else            data    = ex_wdata;
        end
`ifdef OPF_MEM_FWD_EN
        else if (mem_hit) begin
            data = mem_wdata;
        end
`else
        else if (mem_hit) begin
            pending = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-side operand fetch: drives both RF read ports, forwards EX/MEM results, stalls on
// load-use hazards and registers the resolved operands into ID/EX. Build macro: OPF_MEM_FWD_EN.
module id_operand_fetch
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    id_operand_fetch_if.slave dec,
    output logic              rf_re1_o,
    output logic              rf_re2_o,
    output logic [ADDR_W-1:0] rf_raddr1_o,
    output logic [ADDR_W-1:0] rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata1_i,
    input  logic [DATA_W-1:0] rf_rdata2_i,
    input  logic              ex_wreg_i,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic              out_valid,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o
);
    logic [DATA_W-1:0] fwd1, fwd2;
    logic              pend1, pend2;
    logic [DATA_W-1:0] op1_next, op2_next;
    logic              lu;
    idex_upd_e         upd;

    assign rf_re1_o    = (dec.in_valid && dec.use_rs_i) ? RE_ON : RE_OFF;
    assign rf_re2_o    = (dec.in_valid && dec.use_rt_i) ? RE_ON : RE_OFF;
    assign rf_raddr1_o = dec.rs_i;
    assign rf_raddr2_o = dec.rt_i;

    opf_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
        .addr       (dec.rs_i),
        .rf_data    (rf_rdata1_i),
        .ex_wreg    (ex_wreg_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .ex_is_load (ex_is_load_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .data       (fwd1),
        .pending    (pend1)
    );

    opf_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
        .addr       (dec.rt_i),
        .rf_data    (rf_rdata2_i),
        .ex_wreg    (ex_wreg_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .ex_is_load (ex_is_load_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .data       (fwd2),
        .pending    (pend2)
    );

    assign op1_next = dec.use_rs_i ? fwd1 : DATA_W'(ZERO_WORD);
    assign op2_next = dec.use_rt_i ? fwd2 : dec.imm_i;

    // Only a source the instruction actually reads can cause a hazard.
    assign lu           = dec.in_valid && ((dec.use_rs_i && pend1) || (dec.use_rt_i && pend2));
    assign stall_req_o  = lu && !flush_i;
    assign dec.in_ready = flush_i || (!hold_i && !lu);

    always_comb begin
        upd = UPD_BUBBLE;
        if (flush_i)           upd = UPD_BUBBLE;
        else if (hold_i)       upd = UPD_HOLD;
        else if (lu)           upd = UPD_BUBBLE;
        else if (dec.in_valid) upd = UPD_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            op1_o     <= '0;
            op2_o     <= '0;
            wd_o      <= '0;
            wreg_o    <= WE_OFF;
        end else begin
            case (upd)
                UPD_LOAD: begin
                    out_valid <= 1'b1;
                    op1_o     <= op1_next;
                    op2_o     <= op2_next;
                    wd_o      <= dec.wd_i;
                    wreg_o    <= dec.wreg_i;
                end
                UPD_BUBBLE: begin
                    out_valid <= 1'b0;
                    wreg_o    <= WE_OFF;
                end
                default: ;
            endcase
        end
    end

endmodule
